// File: rtl/acc_sequencer.sv
// acc_sequencer: command-driven write sequencer for an 8-bit latch accumulator.
// It accepts one op at a time over a valid/ready port. It presents the
// accumulator and the operand to an external ALU. It writes the result back
// through a setup / gate / hold sequence, repeating ops 1-5 count+1 times.
// Optional feature: define ACC_OVF_FLAG_EN to build the sticky overflow flag.
module acc_sequencer (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    input  logic [3:0] cmd_count_i,
    input  logic [7:0] acc_q_i,
    output logic [7:0] acc_d_o,
    output logic       acc_en_o,
    output logic       acc_rst_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_result_i,
    input  logic       alu_carry_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ovf_o
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SETUP = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state_q;
    logic [2:0] op_q;
    logic [7:0] operand_q;
    logic [3:0] remaining_q;
    logic [7:0] acc_d_q;
    logic       acc_en_q;
    logic       done_q;
    logic       busy_q;
    logic       ready_q;

    logic accept;
    logic op_is_arith;

    assign accept      = (state_q == S_IDLE) && cmd_valid_i;
    assign op_is_arith = (op_q >= OP_ADD) && (op_q <= OP_XOR);

    // Sequencer FSM; every output it drives is a register, so the latch gate
    // never glitches and reset clears the gate without waiting for a clock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            operand_q   <= 8'h00;
            remaining_q <= 4'd0;
            acc_d_q     <= 8'h00;
            acc_en_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            acc_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op_i;
                        operand_q <= cmd_data_i;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        if (cmd_op_i == OP_NOP) begin
                            remaining_q <= 4'd0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (cmd_op_i == OP_LOAD) begin
                            remaining_q <= 4'd0;
                            acc_d_q     <= cmd_data_i;
                            state_q     <= S_SETUP;
                        end else if (cmd_op_i == OP_CLR) begin
                            remaining_q <= 4'd0;
                            acc_d_q     <= 8'h00;
                            state_q     <= S_SETUP;
                        end else begin
                            remaining_q <= cmd_count_i;
                            state_q     <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // The ALU result is taken as-is; width truncation is the ALU's job.
                    acc_d_q <= alu_result_i;
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    acc_en_q <= 1'b1;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (op_is_arith && (remaining_q != 4'd0)) begin
                        remaining_q <= remaining_q - 4'd1;
                        state_q     <= S_EXEC;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACC_OVF_FLAG_EN
    logic ovf_q;

    // Sticky overflow: set by a carry/borrow out of ADD or SUB, cleared by CLR.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB))
                     && alu_carry_i) begin
            ovf_q <= 1'b1;
        end else if (accept && (cmd_op_i == OP_CLR)) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry_i;
    assign ovf_o        = 1'b0;
`endif

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign acc_d_o     = acc_d_q;
    assign acc_en_o    = acc_en_q;
    assign acc_rst_o   = reset_i;
    assign alu_a_o     = acc_q_i;
    assign alu_b_o     = operand_q;
    assign alu_op_o    = op_q;

endmodule
